// File: rtl/rf_wb_unit_if.sv
// Writeback bundle: ALU and load-response sources, decode issue/hazard
// queries, and the register file write port.
// The master view belongs to the writeback unit; the slave view is the
// surrounding pipeline and register file.
interface rf_wb_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM        = 32
);
    // ALU result source
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    // Load response source
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_data;

    // Decode issue and hazard query
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;
    logic [ADDR_WIDTH-1:0] chk_rs1;
    logic [ADDR_WIDTH-1:0] chk_rs2;
    logic                  hazard;

    // Register file write port
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
        output issue_ready, hazard,
        output wen, waddr, wdata
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  issue_ready, hazard,
        input  wen, waddr, wdata
    );
endinterface

// File: rtl/rf_wb_unit.sv
// Register file writeback unit.
// Arbitrates ALU results against load responses (loads first, with a
// starvation guard that hands the ALU one grant after three blocked cycles),
// registers the winning write onto the register file port, and keeps a
// per-register busy scoreboard for decode hazard detection and WAW gating.
module rf_wb_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_wb_unit_if.master  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            starve_q, starve_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM-1:0]        busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic alu_grant;
    logic alu_ready_c;
    logic mem_ready_c;
    logic alu_fire;
    logic mem_fire;

    // Saturated starve counter forces one ALU grant and blocks loads.
    assign alu_grant   = (starve_q == 2'd3);
    // Readies depend only on mem_valid and the counter, never on alu_valid.
    assign alu_ready_c = alu_grant || !bus.mem_valid;
    assign mem_ready_c = !alu_grant;

    // The two grants are mutually exclusive by construction.
    assign alu_fire = bus.alu_valid && alu_ready_c;
    assign mem_fire = bus.mem_valid && mem_ready_c;

    assign bus.alu_ready = alu_ready_c;
    assign bus.mem_ready = mem_ready_c;

    // Count edges on which the ALU is held off by a load; clear once it wins
    // or stops asking.
    always_comb begin
        starve_d = starve_q;
        if (alu_fire || !bus.alu_valid) begin
            starve_d = 2'd0;
        end else if (bus.mem_valid && (starve_q != 2'd3)) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Load the winner; writes to x0 complete the handshake but never assert
    // wen. With no transfer the address and data simply hold.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (mem_fire) begin
            wen_d   = (bus.mem_rd != '0);
            waddr_d = bus.mem_rd;
            wdata_d = bus.mem_data;
        end else if (alu_fire) begin
            wen_d   = (bus.alu_rd != '0);
            waddr_d = bus.alu_rd;
            wdata_d = bus.alu_data;
        end
    end

    assign bus.wen   = wen_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    logic           issue_ready_c;
    logic           issue_fire;
    logic [NUM-1:0] set_vec;
    logic [NUM-1:0] clr_vec;

    // No bypass: a register clearing on this edge still blocks reissue now.
    assign issue_ready_c = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
    assign issue_fire    = bus.issue_valid && issue_ready_c && (bus.issue_rd != '0);

    assign bus.issue_ready = issue_ready_c;
    assign bus.hazard      = ((bus.chk_rs1 != '0) && busy_q[bus.chk_rs1]) ||
                             ((bus.chk_rs2 != '0) && busy_q[bus.chk_rs2]);

    // Per-register next state: the clear lands with the register file commit
    // (wen_q), and a same-edge reissue of that index wins over the clear.
    // x0 is never tracked.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
                assign busy_d[gi]  = 1'b0;
            end else begin : g_reg
                assign set_vec[gi] = issue_fire && (bus.issue_rd == ADDR_WIDTH'(gi));
                assign clr_vec[gi] = wen_q && (waddr_q == ADDR_WIDTH'(gi));
                assign busy_d[gi]  = set_vec[gi] || (busy_q[gi] && !clr_vec[gi]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // All state drops immediately on reset, including any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 2'd0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

endmodule
